inst_issuer: RTL and testbench

Program sequencer that drives the DSP controller's instruction handshake from the other end. On `start` it fetches `prog_len` 32-bit instructions in order from an instruction BRAM (1-cycle read latency). It presents each one on `ctrl_inst` with `ctrl_en`, waits for the controller's `valid`, then releases `ctrl_en` and waits for `valid` to fall before issuing the next. It counts executed (bit 31 = 1) instructions, reports completion, and aborts with an error if the controller fails to respond.

---
 rtl/inst_issuer_if.sv | 29 ++
 rtl/inst_issuer.sv | 143 ++++++++++++++
 tb/tb_inst_issuer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_issuer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : inst_issuer_if                                            |
// | Brief    : Instruction BRAM read port plus controller handshake.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface inst_issuer_if #(
  parameter int AW = 10
) ();
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [31:0]   imem_dout;
  logic          ctrl_en;
  logic [31:0]   ctrl_inst;
  logic          ctrl_valid;

  // The issuer drives the BRAM address/enable and the controller request.
  modport master (
    output imem_addr, imem_en, ctrl_en, ctrl_inst,
    input  imem_dout, ctrl_valid
  );

  // BRAM and controller side of the same bundle.
  modport slave (
    input  imem_addr, imem_en, ctrl_en, ctrl_inst,
    output imem_dout, ctrl_valid
  );
endinterface
`default_nettype wire

// File: rtl/inst_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : inst_issuer                                               |
// | Brief    : Fetches a program from instruction BRAM and issues each   |
// |            word to the DSP controller over an en/valid handshake,    |
// |            counting executed instructions and aborting on timeout.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module inst_issuer #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] prog_len_i,
  inst_issuer_if.master issue_bus,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   exec_cnt_o,
  output logic [AW-1:0] pc_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  localparam logic [7:0] TMO_MAX   = 8'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] len_q;
  logic [AW-1:0] pc_q;
  logic [31:0]   inst_q;
  logic [15:0]   exec_q;
  logic          err_q;
  logic [7:0]    tmo_q;

  logic          start_ok;
  logic          last_inst;
  logic          tmo_hit;

  // A new program is only accepted from the resting states.
  assign start_ok  = start_i &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign last_inst = (pc_q == (len_q - AW'(1)));
  assign tmo_hit   = (tmo_q == TMO_MAX);

  // State register; reset drops ctrl_en immediately since outputs decode this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a response from the controller wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_i) state_d = (prog_len_i == '0) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        if (start_i) state_d = (prog_len_i == '0) ? S_DONE : S_FETCH;
        else         state_d = S_IDLE;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (issue_bus.ctrl_valid) state_d = S_RELEASE;
        else if (tmo_hit)         state_d = S_ERR;
      end
      S_RELEASE: begin
        if (!issue_bus.ctrl_valid) state_d = last_inst ? S_DONE : S_FETCH;
        else if (tmo_hit)          state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the state register plus the registered datapath values.
  always_comb begin
    issue_bus.imem_en   = (state_q == S_FETCH);
    issue_bus.imem_addr = pc_q;
    issue_bus.ctrl_en   = (state_q == S_ISSUE);
    issue_bus.ctrl_inst = inst_q;
    busy_o     = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                 (state_q == S_ISSUE) || (state_q == S_RELEASE);
    done_o     = (state_q == S_DONE);
    err_o      = err_q;
    exec_cnt_o = exec_q;
    pc_o       = pc_q;
  end

  // Datapath: program length, pc, instruction hold register, counters and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      pc_q   <= '0;
      inst_q <= '0;
      exec_q <= '0;
      err_q  <= 1'b0;
      tmo_q  <= '0;
    end else begin
      if (start_ok) begin
        len_q  <= prog_len_i;
        pc_q   <= '0;
        exec_q <= '0;
        err_q  <= 1'b0;
      end else if (state_d == S_ERR) begin
        err_q  <= 1'b1;
      end

      case (state_q)
        S_LOAD: begin
          inst_q <= issue_bus.imem_dout;
          tmo_q  <= '0;
        end
        S_ISSUE: begin
          if (issue_bus.ctrl_valid) begin
            tmo_q <= '0;
            if (inst_q[31] && (exec_q != 16'hFFFF)) exec_q <= exec_q + 16'd1;
          end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_RELEASE: begin
          if (!issue_bus.ctrl_valid) begin
            if (!last_inst) pc_q <= pc_q + AW'(1);
          end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_inst_issuer                                            |
// | Brief    : Self-checking bench for inst_issuer with BRAM and         |
// |            controller models and an issue-order scoreboard.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_inst_issuer;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] prog_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   exec_cnt;
  logic [AW-1:0] pc;

  inst_issuer_if #(.AW(AW)) ifc ();

  inst_issuer #(.TIMEOUT(8), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .prog_len_i (prog_len),
    .issue_bus  (ifc),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .exec_cnt_o (exec_cnt),
    .pc_o       (pc)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] exp_q [$];
  int          rise_cyc [$];
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          imem_cnt = 0;
  int          cyc      = 0;

  // Controller model: 0 = normal, 1 = never responds, 2 = valid sticks high once raised
  int mode      = 0;
  bit stuck_hit = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: data appears the cycle after the enable is seen
  initial begin
    bit            mpend;
    logic [AW-1:0] maddr;
    mpend = 0;
    maddr = '0;
    ifc.imem_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mpend) ifc.imem_dout = mem[maddr];
      mpend = ifc.imem_en;
      maddr = ifc.imem_addr;
    end
  end

  // Controller model: valid follows ctrl_en with a 1-cycle lag (NOP) or 6 cycles (bit 31 set),
  // and falls the cycle after ctrl_en drops
  initial begin
    int ccnt;
    int clat;
    ccnt = 0;
    clat = 1;
    ifc.ctrl_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) ifc.ctrl_valid = 1'b0;
      else if (mode == 2 && stuck_hit) ifc.ctrl_valid = 1'b1;
      else begin
        ifc.ctrl_valid = (ccnt > 0) && (ccnt >= clat);
        if (mode == 2 && ifc.ctrl_valid) stuck_hit = 1;
      end
      if (ifc.ctrl_en) begin
        ccnt++;
        clat = ifc.ctrl_inst[31] ? 6 : 1;
      end else begin
        ccnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard at each issue window and checks ctrl_inst stays stable
  initial begin
    logic        en_prev;
    logic [31:0] held;
    logic [31:0] exp;
    en_prev = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ifc.imem_en) imem_cnt++;
      if (done) done_cnt++;
      if (ifc.ctrl_en && !en_prev) begin
        rise_cnt++;
        rise_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_window: ctrl_inst=%h issued but nothing expected", ifc.ctrl_inst);
        end else begin
          exp = exp_q.pop_front();
          if (ifc.ctrl_inst !== exp) begin
            errors++;
            $display("FAIL issue_inst: got %h expected %h", ifc.ctrl_inst, exp);
          end
        end
        held = ifc.ctrl_inst;
      end else if (ifc.ctrl_en) begin
        checks++;
        if (ifc.ctrl_inst !== held) begin
          errors++;
          $display("FAIL inst_stable: got %h expected %h", ifc.ctrl_inst, held);
        end
      end
      en_prev = ifc.ctrl_en;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Pulse start for one cycle; returns at the negedge of cycle 1 after the accepting edge
  task automatic start_prog(input logic [AW-1:0] len);
    @(negedge clk);
    start    = 1'b1;
    prog_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit hit);
    hit = 0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_en(input int max, output bit hit);
    hit = 0;
    for (int i = 0; i < max; i++) begin
      if (ifc.ctrl_en) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    start    = 1'b0;
    prog_len = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.ctrl_en, ifc.imem_en, busy, done, err, exec_cnt, pc, ifc.ctrl_inst, ifc.imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_in: outputs not zero en=%b ien=%b busy=%b done=%b err=%b cnt=%h pc=%h inst=%h expected all 0",
               ifc.ctrl_en, ifc.imem_en, busy, done, err, exec_cnt, pc, ifc.ctrl_inst);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.ctrl_en, ifc.imem_en, busy, done, err, exec_cnt, pc, ifc.ctrl_inst, ifc.imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_out: outputs not zero after release busy=%b done=%b err=%b expected all 0",
               busy, done, err);
    end
  endtask

  task automatic test_three();
    int base, dbase;
    bit hit;
    mem[0] = 32'h8000_0000;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'h8123_4567;
    mode = 0;
    base  = rise_cnt;
    dbase = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
    start_prog(3);
    checks++;
    if ({ifc.imem_en, busy, ifc.imem_addr} !== {1'b1, 1'b1, 10'd0}) begin
      errors++;
      $display("FAIL three_fetch: ien=%b busy=%b addr=%h expected 1 1 0", ifc.imem_en, busy, ifc.imem_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.ctrl_en, ifc.ctrl_inst} !== {1'b1, 32'h8000_0000}) begin
      errors++;
      $display("FAIL three_issue_c3: en=%b inst=%h expected 1 80000000", ifc.ctrl_en, ifc.ctrl_inst);
    end
    wait_done(200, hit);
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL three_done: got no done expected done within 200 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - dbase !== 1) begin
      errors++;
      $display("FAIL three_done_cnt: got %0d expected 1", done_cnt - dbase);
    end
    checks++;
    if (rise_cnt - base !== 3) begin
      errors++;
      $display("FAIL three_windows: got %0d expected 3", rise_cnt - base);
    end
    checks++;
    if ({exec_cnt, err, pc} !== {16'd2, 1'b0, 10'd2}) begin
      errors++;
      $display("FAIL three_final: cnt=%0d err=%b pc=%0d expected 2 0 2", exec_cnt, err, pc);
    end
    checks++;
    if (rise_cnt - base == 3 && rise_cyc[base+2] - rise_cyc[base+1] !== 6) begin
      errors++;
      $display("FAIL nop_period: got %0d expected 6", rise_cyc[base+2] - rise_cyc[base+1]);
    end
  endtask

  task automatic test_zero_len();
    int ibase, rbase;
    ibase = imem_cnt;
    rbase = rise_cnt;
    start_prog(0);
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL zero_done_c1: done=%b busy=%b expected 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse: got %b expected 0", done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({imem_cnt - ibase, rise_cnt - rbase} !== {32'd0, 32'd0} || exec_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_activity: imem=%0d windows=%0d cnt=%0d expected 0 0 0",
               imem_cnt - ibase, rise_cnt - rbase, exec_cnt);
    end
  endtask

  task automatic test_timeout();
    int n, dbase;
    bit hit;
    mode = 1;
    mem[0] = 32'h0000_1111;
    exp_q.push_back(mem[0]);
    dbase = done_cnt;
    start_prog(4);
    wait_en(20, hit);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    checks++;
    if (n !== 9 || err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles err=%b expected 9 cycles err=1", n, err);
    end
    checks++;
    if ({ifc.ctrl_en, busy, pc} !== {1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL tmo_state: en=%b busy=%b pc=%0d expected 0 0 0", ifc.ctrl_en, busy, pc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== dbase || err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: done_pulses=%0d err=%b expected 0 1", done_cnt - dbase, err);
    end
    mode = 0;
    mem[0] = 32'h8000_0001;
    mem[1] = 32'h0000_0002;
    exp_q.push_back(mem[0]);
    exp_q.push_back(mem[1]);
    start_prog(2);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_clear: got %b expected 0", err);
    end
    wait_done(100, hit);
    checks++;
    if (!hit || exec_cnt !== 16'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rerun: done=%b cnt=%0d err=%b expected 1 1 0", hit, exec_cnt, err);
    end
  endtask

  task automatic test_stuck_valid();
    int n;
    bit hit;
    @(negedge clk);
    mode      = 2;
    stuck_hit = 0;
    mem[0] = 32'h8000_0003;
    mem[1] = 32'h0000_0004;
    exp_q.push_back(mem[0]);
    start_prog(3);
    wait_en(20, hit);
    for (int i = 0; i < 30; i++) begin
      if (!ifc.ctrl_en) break;
      @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    checks++;
    if (n !== 9 || err !== 1'b1) begin
      errors++;
      $display("FAIL stuck_latency: got %0d cycles err=%b expected 9 cycles err=1", n, err);
    end
    checks++;
    if ({exec_cnt, pc, ifc.ctrl_en} !== {16'd1, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL stuck_state: cnt=%0d pc=%0d en=%b expected 1 0 0", exec_cnt, pc, ifc.ctrl_en);
    end
    mode      = 0;
    stuck_hit = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit;
    mem[0] = 32'h8000_0010;
    mem[1] = 32'h0000_0020;
    mem[2] = 32'h8000_0030;
    for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
    start_prog(3);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (ifc.ctrl_en && ifc.ctrl_inst === 32'h0000_0020) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!hit || {ifc.ctrl_en, ifc.imem_en, busy, done, err, exec_cnt, pc, ifc.ctrl_inst} !== '0) begin
      errors++;
      $display("FAIL reset_mid: reached=%b en=%b busy=%b cnt=%0d pc=%0d inst=%h expected all 0",
               hit, ifc.ctrl_en, busy, exec_cnt, pc, ifc.ctrl_inst);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
    start_prog(3);
    checks++;
    if ({ifc.imem_en, ifc.imem_addr} !== {1'b1, 10'd0}) begin
      errors++;
      $display("FAIL reset_rerun_fetch: ien=%b addr=%0d expected 1 0", ifc.imem_en, ifc.imem_addr);
    end
    wait_done(200, hit);
    checks++;
    if (!hit || {exec_cnt, pc, err} !== {16'd2, 10'd2, 1'b0}) begin
      errors++;
      $display("FAIL reset_rerun: done=%b cnt=%0d pc=%0d err=%b expected 1 2 2 0", hit, exec_cnt, pc, err);
    end
  endtask

  task automatic test_start_busy();
    int base;
    bit hit;
    repeat (2) @(negedge clk);
    mem[0] = 32'h0000_0100;
    mem[1] = 32'h8000_0200;
    mem[2] = 32'h8000_0300;
    for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
    base = rise_cnt;
    start_prog(3);
    wait_en(20, hit);
    start    = 1'b1;
    prog_len = 10'd1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(200, hit);
    repeat (2) @(negedge clk);
    checks++;
    if (!hit || rise_cnt - base !== 3) begin
      errors++;
      $display("FAIL busy_start_windows: done=%b windows=%0d expected 1 3", hit, rise_cnt - base);
    end
    checks++;
    if ({exec_cnt, pc} !== {16'd2, 10'd2} || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL busy_start_final: cnt=%0d pc=%0d left=%0d expected 2 2 0", exec_cnt, pc, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_three();
    test_zero_len();
    test_timeout();
    test_stuck_valid();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
